// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, default datapath widths and the
// writeback sequencer state encoding.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 4;
  localparam int unsigned SEL_W_DEF      = 5;

  localparam logic [SEL_W_DEF-1:0] OP_ADD  = 5'd0;
  localparam logic [SEL_W_DEF-1:0] OP_SUB  = 5'd1;
  localparam logic [SEL_W_DEF-1:0] OP_MUL  = 5'd2;
  localparam logic [SEL_W_DEF-1:0] OP_DIV  = 5'd3;
  localparam logic [SEL_W_DEF-1:0] OP_AND  = 5'd4;
  localparam logic [SEL_W_DEF-1:0] OP_OR   = 5'd5;
  localparam logic [SEL_W_DEF-1:0] OP_SHL  = 5'd6;
  localparam logic [SEL_W_DEF-1:0] OP_SHR  = 5'd7;
  localparam logic [SEL_W_DEF-1:0] OP_ROL  = 5'd8;
  localparam logic [SEL_W_DEF-1:0] OP_ROR  = 5'd9;
  localparam logic [SEL_W_DEF-1:0] OP_NEG  = 5'd10;
  localparam logic [SEL_W_DEF-1:0] OP_XOR  = 5'd11;
  localparam logic [SEL_W_DEF-1:0] OP_NOR  = 5'd12;
  localparam logic [SEL_W_DEF-1:0] OP_NAND = 5'd13;
  localparam logic [SEL_W_DEF-1:0] OP_LAST = 5'd13;

  typedef enum logic [1:0] {
    StIdle,
    StWrMain,
    StWrHi
  } wb_state_e;

endpackage

// File: rtl/alu_result_writeback_if.sv
// Handshake bundle between the ALU, the writeback stage and the register file.
//   in_*      : ALU result capture handshake (valid/ready + sel, result, dest)
//   wb_*      : register-file write beat handshake and target strobes
// slave  : writeback stage view;  master : ALU/register-file side view.
interface alu_result_writeback_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned SEL_W      = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [SEL_W-1:0]      alu_sel;
  logic [2*DATA_W-1:0]   alu_out;
  logic [REG_ADDR_W-1:0] dest_reg;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  gpr_we;
  logic                  lo_we;
  logic                  hi_we;

  modport slave (
    input  in_valid, alu_sel, alu_out, dest_reg, wb_ready,
    output in_ready, wb_valid, wb_addr, wb_data, gpr_we, lo_we, hi_we
  );

  modport master (
    output in_valid, alu_sel, alu_out, dest_reg, wb_ready,
    input  in_ready, wb_valid, wb_addr, wb_data, gpr_we, lo_we, hi_we
  );
endinterface

// File: rtl/alu_result_writeback.sv
// Writeback stage after the 64-bit ALU. Captures one result per handshake and
// sequences it onto a 32-bit register-file write port: one GPR beat for
// single-word ops, LO then HI beats for mul/div. Keeps zero/negative flags and
// flags illegal ALU selections.
// Ports:
//   clk, clr_n  : clock, asynchronous active-low reset
//   bus         : capture + write-beat handshake bundle (slave view)
//   flag_z/n    : flags of the last accepted legal result
//   err_illegal : one-cycle pulse after an illegal alu_sel is captured
module alu_result_writeback
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned SEL_W      = SEL_W_DEF
) (
  input  logic                   clk,
  input  logic                   clr_n,
  alu_result_writeback_if.slave  bus,
  output logic                   flag_z,
  output logic                   flag_n,
  output logic                   err_illegal
);

  wb_state_e             state_q, state_d;
  logic [2*DATA_W-1:0]   z_q, z_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic                  gpr_we_q, gpr_we_d;
  logic                  lo_we_q, lo_we_d;
  logic                  hi_we_q, hi_we_d;
  logic                  flag_z_q, flag_z_d;
  logic                  flag_n_q, flag_n_d;
  logic                  err_q, err_d;

  logic capture, in_legal, in_wide, in_mul, held_wide;

  assign bus.in_ready = (state_q == StIdle);
  assign capture      = bus.in_valid && (state_q == StIdle);
  assign in_legal     = (bus.alu_sel <= SEL_W'(OP_LAST));
  assign in_mul       = (bus.alu_sel == SEL_W'(OP_MUL));
  assign in_wide      = in_mul || (bus.alu_sel == SEL_W'(OP_DIV));
  assign held_wide    = (sel_q == SEL_W'(OP_MUL)) || (sel_q == SEL_W'(OP_DIV));

  // Beat outputs are computed for the next state so they leave the block
  // registered and stay put while the register file stalls.
  always_comb begin
    state_d    = state_q;
    z_d        = z_q;
    sel_d      = sel_q;
    dest_d     = dest_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_addr_d  = wb_addr_q;
    gpr_we_d   = gpr_we_q;
    lo_we_d    = lo_we_q;
    hi_we_d    = hi_we_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    err_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          z_d    = bus.alu_out;
          sel_d  = bus.alu_sel;
          dest_d = bus.dest_reg;
          if (in_legal) begin
            state_d    = StWrMain;
            wb_valid_d = 1'b1;
            wb_data_d  = bus.alu_out[DATA_W-1:0];
            if (in_wide) begin
              lo_we_d   = 1'b1;
              wb_addr_d = '0;
            end else begin
              gpr_we_d  = 1'b1;
              wb_addr_d = bus.dest_reg;
            end
            // Mul flags cover the full product; div uses the quotient only.
            if (in_mul) begin
              flag_z_d = (bus.alu_out == '0);
              flag_n_d = bus.alu_out[2*DATA_W-1];
            end else begin
              flag_z_d = (bus.alu_out[DATA_W-1:0] == '0);
              flag_n_d = bus.alu_out[DATA_W-1];
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWrMain: begin
        if (bus.wb_ready) begin
          if (held_wide) begin
            state_d   = StWrHi;
            wb_data_d = z_q[2*DATA_W-1:DATA_W];
            wb_addr_d = '0;
            lo_we_d   = 1'b0;
            hi_we_d   = 1'b1;
          end else begin
            state_d    = StIdle;
            wb_valid_d = 1'b0;
            wb_data_d  = '0;
            wb_addr_d  = '0;
            gpr_we_d   = 1'b0;
          end
        end
      end
      StWrHi: begin
        if (bus.wb_ready) begin
          state_d    = StIdle;
          wb_valid_d = 1'b0;
          wb_data_d  = '0;
          wb_addr_d  = '0;
          hi_we_d    = 1'b0;
        end
      end
      default: begin
        state_d    = StIdle;
        wb_valid_d = 1'b0;
        wb_data_d  = '0;
        wb_addr_d  = '0;
        gpr_we_d   = 1'b0;
        lo_we_d    = 1'b0;
        hi_we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= StIdle;
      z_q        <= '0;
      sel_q      <= '0;
      dest_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_addr_q  <= '0;
      gpr_we_q   <= 1'b0;
      lo_we_q    <= 1'b0;
      hi_we_q    <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      z_q        <= z_d;
      sel_q      <= sel_d;
      dest_q     <= dest_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_addr_q  <= wb_addr_d;
      gpr_we_q   <= gpr_we_d;
      lo_we_q    <= lo_we_d;
      hi_we_q    <= hi_we_d;
      flag_z_q   <= flag_z_d;
      flag_n_q   <= flag_n_d;
      err_q      <= err_d;
    end
  end

  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_addr  = wb_addr_q;
  assign bus.gpr_we   = gpr_we_q;
  assign bus.lo_we    = lo_we_q;
  assign bus.hi_we    = hi_we_q;
  assign flag_z       = flag_z_q;
  assign flag_n       = flag_n_q;
  assign err_illegal  = err_q;

endmodule

// File: tb/tb_alu_result_writeback.sv
// Scenario bench for alu_result_writeback. Expected write beats are queued when
// a result is presented and compared by a monitor when the register file
// accepts each beat; each scenario task checks timing, strobes and flags.
module tb_alu_result_writeback;

  typedef struct {
    logic [1:0]  kind;  // 0 gpr, 1 lo, 2 hi
    logic [3:0]  addr;
    logic [31:0] data;
  } beat_t;

  logic clk;
  logic clr_n;
  logic flag_z, flag_n, err_illegal;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  beat_t sb[$];
  logic exp_z = 1'b0;
  logic exp_n = 1'b0;

  alu_result_writeback_if #(.DATA_W(32), .REG_ADDR_W(4), .SEL_W(5)) bus ();

  alu_result_writeback dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .bus         (bus),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .err_illegal (err_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference flags and beats for a legal op.
  task automatic model_push(input logic [4:0] sel, input logic [63:0] out, input logic [3:0] dest);
    beat_t b;
    if (sel > 5'd13) return;
    if (sel == 5'd2) begin
      exp_z = (out == 64'd0);
      exp_n = out[63];
    end else begin
      exp_z = (out[31:0] == 32'd0);
      exp_n = out[31];
    end
    if (sel == 5'd2 || sel == 5'd3) begin
      b.kind = 2'd1; b.addr = 4'd0; b.data = out[31:0];  sb.push_back(b);
      b.kind = 2'd2; b.addr = 4'd0; b.data = out[63:32]; sb.push_back(b);
    end else begin
      b.kind = 2'd0; b.addr = dest; b.data = out[31:0]; sb.push_back(b);
    end
  endtask

  // Accepted-beat monitor and strobe exclusivity check.
  always @(negedge clk) begin
    if (clr_n) begin
      chk_cnt++;
      if (bus.wb_valid ? ({bus.gpr_we, bus.lo_we, bus.hi_we} != 3'b100 &&
                          {bus.gpr_we, bus.lo_we, bus.hi_we} != 3'b010 &&
                          {bus.gpr_we, bus.lo_we, bus.hi_we} != 3'b001)
                       : ({bus.gpr_we, bus.lo_we, bus.hi_we} != 3'b000))
        $display("FAIL strobe_excl: valid=%0b we=%b", bus.wb_valid,
                 {bus.gpr_we, bus.lo_we, bus.hi_we});
      else pass_cnt++;
      if (bus.wb_valid && bus.wb_ready) begin
        beat_t e;
        logic [1:0] kind;
        kind = bus.lo_we ? 2'd1 : (bus.hi_we ? 2'd2 : 2'd0);
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL beat_unexpected: kind=%0d addr=%0d data=%h", kind, bus.wb_addr,
                   bus.wb_data);
        end else begin
          e = sb.pop_front();
          if (kind !== e.kind || bus.wb_addr !== e.addr || bus.wb_data !== e.data)
            $display("FAIL beat: got kind=%0d addr=%0d data=%h want kind=%0d addr=%0d data=%h",
                     kind, bus.wb_addr, bus.wb_data, e.kind, e.addr, e.data);
          else pass_cnt++;
        end
      end
    end
  end

  // Present one result for a single capture edge; starts just after a posedge.
  task automatic send(input logic [4:0] sel, input logic [63:0] out, input logic [3:0] dest);
    bus.in_valid = 1'b1;
    bus.alu_sel  = sel;
    bus.alu_out  = out;
    bus.dest_reg = dest;
    model_push(sel, out, dest);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.alu_out  = 64'hA5A5_5A5A_C3C3_3C3C;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    bus.in_valid = 1'b0; bus.wb_ready = 1'b1;
    bus.alu_sel = '0; bus.alu_out = '0; bus.dest_reg = '0;
    repeat (3) @(posedge clk);
    #2 clr_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0 || flag_z !== 1'b0 ||
        flag_n !== 1'b0 || err_illegal !== 1'b0)
      $display("FAIL reset: rdy=%b v=%b z=%b n=%b err=%b want 1 0 0 0 0", bus.in_ready,
               bus.wb_valid, flag_z, flag_n, err_illegal);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bus.wb_ready = 1'b1;
    send(5'd0, 64'h0000_0000_0000_0005, 4'd3);
    @(negedge clk);
    chk_cnt++;
    if (bus.wb_valid !== 1'b1 || bus.gpr_we !== 1'b1 || bus.wb_addr !== 4'd3 ||
        bus.wb_data !== 32'd5 || bus.in_ready !== 1'b0)
      $display("FAIL single_beat: v=%b gpr=%b addr=%0d data=%h rdy=%b want 1 1 3 5 0",
               bus.wb_valid, bus.gpr_we, bus.wb_addr, bus.wb_data, bus.in_ready);
    else pass_cnt++;
    chk_cnt++;
    if (flag_z !== exp_z || flag_n !== exp_n)
      $display("FAIL single_flags: z=%b n=%b want %b %b", flag_z, flag_n, exp_z, exp_n);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0)
      $display("FAIL single_done: rdy=%b v=%b want 1 0", bus.in_ready, bus.wb_valid);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    bus.wb_ready = 1'b1;
    send(5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4'd5);
    @(negedge clk);
    chk_cnt++;
    if (bus.lo_we !== 1'b1 || bus.wb_data !== 32'hFFFF_FFFE || bus.wb_addr !== 4'd0)
      $display("FAIL mul_lo: lo=%b data=%h addr=%0d want 1 fffffffe 0", bus.lo_we,
               bus.wb_data, bus.wb_addr);
    else pass_cnt++;
    chk_cnt++;
    if (flag_n !== 1'b1 || flag_z !== 1'b0)
      $display("FAIL mul_flags: z=%b n=%b want 0 1", flag_z, flag_n);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (bus.hi_we !== 1'b1 || bus.wb_data !== 32'hFFFF_FFFF)
      $display("FAIL mul_hi: hi=%b data=%h want 1 ffffffff", bus.hi_we, bus.wb_data);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0)
      $display("FAIL mul_done: rdy=%b v=%b want 1 0", bus.in_ready, bus.wb_valid);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    bus.wb_ready = 1'b0;
    send(5'd3, {32'd7, 32'd0}, 4'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (bus.wb_valid !== 1'b1 || bus.lo_we !== 1'b1 || bus.wb_data !== 32'd0 ||
          bus.in_ready !== 1'b0 || flag_z !== 1'b1)
        $display("FAIL stall_hold%0d: v=%b lo=%b data=%h rdy=%b z=%b want 1 1 0 0 1", i,
                 bus.wb_valid, bus.lo_we, bus.wb_data, bus.in_ready, flag_z);
      else pass_cnt++;
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (bus.hi_we !== 1'b1 || bus.wb_data !== 32'd7)
      $display("FAIL stall_hi: hi=%b data=%h want 1 7", bus.hi_we, bus.wb_data);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic z0, n0;
    z0 = exp_z; n0 = exp_n;
    bus.wb_ready = 1'b1;
    send(5'd20, 64'h8000_0000_0000_0000, 4'd2);
    @(negedge clk);
    chk_cnt++;
    if (err_illegal !== 1'b1 || bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        flag_z !== z0 || flag_n !== n0)
      $display("FAIL illegal: err=%b v=%b rdy=%b z=%b n=%b want 1 0 1 %b %b", err_illegal,
               bus.wb_valid, bus.in_ready, flag_z, flag_n, z0, n0);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (err_illegal !== 1'b0)
      $display("FAIL illegal_pulse: err=%b want 0", err_illegal);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  sels[5]  = '{5'd0, 5'd2, 5'd4, 5'd3, 5'd11};
    logic [63:0] outs[5]  = '{64'hDEAD_0000_8000_0000, 64'h0000_0001_0000_0000, 64'd0,
                              64'h0000_0005_0000_0003, 64'hFFFF_FFFF_0000_0001};
    logic [3:0]  dests[5] = '{4'd7, 4'd1, 4'd9, 4'd2, 4'd15};
    logic prev_wide = 1'b0;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int waited;
      logic rdy;
      bus.in_valid = 1'b1;
      bus.alu_sel  = sels[i];
      bus.alu_out  = outs[i];
      bus.dest_reg = dests[i];
      waited = 0;
      do begin
        @(negedge clk);
        rdy = bus.in_ready;
        @(posedge clk);
        waited++;
      end while (!rdy && waited < 10);
      #1;
      if (rdy) model_push(sels[i], outs[i], dests[i]);
      if (i > 0) begin
        chk_cnt++;
        if (waited != (prev_wide ? 3 : 2))
          $display("FAIL b2b_rate%0d: cycles=%0d want %0d", i, waited, prev_wide ? 3 : 2);
        else pass_cnt++;
      end
      prev_wide = (sels[i] == 5'd2 || sels[i] == 5'd3);
    end
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (flag_z !== exp_z || flag_n !== exp_n || sb.size() != 0)
      $display("FAIL b2b_end: z=%b n=%b pending=%0d want %b %b 0", flag_z, flag_n, sb.size(),
               exp_z, exp_n);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bus.wb_ready = 1'b0;
    send(5'd2, 64'h1234_5678_9ABC_DEF0, 4'd4);
    @(negedge clk);
    bus.wb_ready = 1'b1;
    @(posedge clk);
    #1 bus.wb_ready = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (bus.hi_we !== 1'b1 || bus.wb_data !== 32'h1234_5678)
      $display("FAIL rmid_hi_pending: hi=%b data=%h want 1 12345678", bus.hi_we, bus.wb_data);
    else pass_cnt++;
    #2 clr_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus.wb_valid !== 1'b0 || bus.hi_we !== 1'b0 || bus.in_ready !== 1'b1 ||
        flag_n !== 1'b0)
      $display("FAIL rmid_async: v=%b hi=%b rdy=%b n=%b want 0 0 1 0", bus.wb_valid,
               bus.hi_we, bus.in_ready, flag_n);
    else pass_cnt++;
    sb.delete();
    exp_z = 1'b0; exp_n = 1'b0;
    #4 clr_n = 1'b1;
    @(posedge clk);
    #1 bus.wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++;
      if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1)
        $display("FAIL rmid_idle%0d: v=%b rdy=%b want 0 1", i, bus.wb_valid, bus.in_ready);
      else pass_cnt++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    chk_cnt++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_empty: pending=%0d want 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Stage directly downstream of the 64-bit ALU.
- Captures one ALU result (the Z pair) per handshake and sequences it onto a single 32-bit register-file write port.
- Single-word ops (add, sub, and, or, shifts, rotates, negate, xor, nor, nand) take one write beat. Mul and div take two beats: LO first, then HI.
- Also maintains zero and negative flags and rejects unknown ALU selections.

Parameters:
- DATA_W, 32, width of one write beat; the ALU result is 2*DATA_W.
- REG_ADDR_W, 4, width of the general-register destination address.
- SEL_W, 5, width of the ALU selection code.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result, selection and destination are valid this cycle.
- in_ready  output  1  block can capture a result this cycle.
- alu_sel  input  SEL_W  ALU operation code for the presented result.
- alu_out  input  2*DATA_W  ALU result. For mul: full product. For div: {remainder, quotient}.
- dest_reg  input  REG_ADDR_W  general-register destination for single-word ops.
- wb_valid  output  1  write beat presented.
- wb_ready  input  1  register file accepts the beat.
- wb_addr  output  REG_ADDR_W  destination for general writes; 0 during HI/LO beats.
- wb_data  output  DATA_W  write data.
- gpr_we  output  1  beat targets general register wb_addr.
- lo_we  output  1  beat targets the LO register.
- hi_we  output  1  beat targets the HI register.
- flag_z  output  1  zero flag of the last accepted legal result.
- flag_n  output  1  negative flag of the last accepted legal result.
- err_illegal  output  1  one-cycle pulse when an illegal alu_sel is accepted.

Behaviour:
- Clocking and reset: one clock, clk. Reset clr_n is asynchronous, active-low.
- Reset values: state IDLE; Z register, sel register, dest register, wb_data, wb_addr all 0; wb_valid, gpr_we, lo_we, hi_we, flag_z, flag_n, err_illegal all 0; in_ready 1 once clr_n deasserts.
- Reset mid-operation: any pending beat is dropped with no partial write. A HI beat is never issued after reset.
- States: IDLE, WR_MAIN, WR_HI.
- in_ready = (state == IDLE). It is a pure combinational decode of state, with no combinational path from wb_ready.
- Capture: on in_valid & in_ready the block registers alu_out, alu_sel and dest_reg.
  - sel 0,1,4..13: go to WR_MAIN.
  - sel 2,3: go to WR_MAIN (LO beat).
  - sel 14..31: stay in IDLE, pulse err_illegal next cycle, flags unchanged, no write.
- Latency: wb_valid rises the cycle after capture.
- WR_MAIN, single-word op: wb_data = Z[DATA_W-1:0], wb_addr = dest, gpr_we = 1. On wb_ready go to IDLE.
- WR_MAIN, mul/div: wb_data = Z[DATA_W-1:0], lo_we = 1, wb_addr = 0. On wb_ready go to WR_HI.
- WR_HI: wb_data = Z[2*DATA_W-1:DATA_W], hi_we = 1. On wb_ready go to IDLE.
- Beat stability: wb_valid, wb_data, wb_addr and the we strobes are registered. They are held stable while wb_valid & !wb_ready; the stall is unbounded.
- Exclusivity: exactly one of gpr_we, lo_we, hi_we is high whenever wb_valid = 1; all are 0 when wb_valid = 0.
- Back-to-back throughput: the final beat is accepted, the state returns to IDLE, in_ready is 1 the following cycle, and the next result is captured in that cycle. Peak rate is one single-word op per 2 cycles and one mul/div per 3 cycles.
- Flags, updated at capture of a legal op:
  - Single-word op: flag_z = (alu_out[DATA_W-1:0] == 0), flag_n = alu_out[DATA_W-1].
  - Mul: flag_z = (alu_out == 0), flag_n = alu_out[2*DATA_W-1].
  - Div: flag_z and flag_n taken from the quotient, alu_out[DATA_W-1:0].
- in_valid while not ready is ignored. The upstream stage holds its result until in_ready.
- X on alu_out with in_valid = 0 must not propagate into state or flags.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU op constants: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_AND=4, OP_OR=5, OP_SHL=6, OP_SHR=7, OP_ROL=8, OP_ROR=9, OP_NEG=10, OP_XOR=11, OP_NOR=12, OP_NAND=13, OP_LAST=13.
  - The writeback state enum.
  - DATA_W and REG_ADDR_W defaults.
- The ALU is updated to use the same constants.
- No sub-module: the FSM, Z register and flag logic stay flat in one module.

Test Plan:
- Reset release: clr_n low then high with in_valid=0. Response: in_ready=1, wb_valid=0, flags 0.
- Single-word op: sel=0, alu_out=64'h0000_0000_0000_0005, dest=3, wb_ready=1. Response: next cycle wb_valid=1, gpr_we=1, wb_addr=3, wb_data=5, flag_z=0, flag_n=0; in_ready returns 1 a cycle later.
- Mul two beats: sel=2, alu_out=64'hFFFF_FFFF_FFFF_FFFE. Response: beat 1 lo_we=1, wb_data=FFFF_FFFE; beat 2 hi_we=1, wb_data=FFFF_FFFF; flag_n=1.
- Stall: div with {rem 7, quot 0}, wb_ready=0 for 4 cycles. Response: LO beat held stable with data 0, flag_z=1, in_ready=0 throughout; HI beat with data 7 follows the accept.
- Illegal op: sel=20 with in_valid=1. Response: err_illegal pulses once, no we strobe, flags unchanged, in_ready stays 1.
- Reset mid-operation: clr_n low during the WR_HI stall. Response: wb_valid and hi_we drop immediately (asynchronous); after release the block is IDLE and no HI beat occurs.
